span_walker: RTL and testbench
==============================

# span_walker

Downstream consumer of the per-scanline triangle interpolator: accepts one horizontal span per transaction (y, x_start, x_end, colour) and serialises it into a pixel stream, one pixel per accepted beat, for the framebuffer/tile writer. Spans are normalised so either endpoint order works. The block provides valid/ready backpressure on both sides and supports back-to-back spans with no bubble.

## Interface
- COORD_W, 10: coordinate width (x and y)
- COLOR_W, 8: pixel colour width
- H_ACTIVE, 640: visible width; used only when clipping is compiled in
- V_ACTIVE, 480: visible height; used only when clipping is compiled in

- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- span_valid  in  1  span offered
- span_ready  out  1  span accepted when valid && ready
- span_y  in  COORD_W  scanline
- span_x_start  in  COORD_W  one endpoint (inclusive)
- span_x_end  in  COORD_W  other endpoint (inclusive)
- span_color  in  COLOR_W  flat colour
- pix_valid  out  1  pixel offered
- pix_ready  in  1  pixel consumed when valid && ready
- pix_x, pix_y  out  COORD_W  pixel coordinate
- pix_color  out  COLOR_W  pixel colour
- pix_last  out  1  final pixel of current span
- busy  out  1  high while in WALK

## Operation
- FSM: IDLE, WALK.
- IDLE: span_ready=1. On accept: lo=min(x_start,x_end), hi=max(...), latch y and colour, cur=lo; go to WALK.
- WALK: pix_valid=1, pix_x=cur, pix_last=(cur==hi). On pixel accept with !pix_last: cur<=cur+1. Hold all outputs stable while pix_valid && !pix_ready.
- span_ready = IDLE || (WALK && pix_last && pix_ready). On accepting the last pixel, the next span may be accepted in the same cycle; FSM stays in WALK with the new span loaded, with no idle cycle. Otherwise it returns to IDLE.
- x_start==x_end: exactly one pixel, pix_last=1.
- cur increments only up to hi, so no wrap-around: hi=2^COORD_W-1 terminates correctly.
- Input fields are sampled only on the accept edge; changes while not accepted are ignored.

## Timing
- Reset (async assert): state=IDLE; pix_valid=0, pix_last=0, busy=0, pix_x=pix_y=pix_color=0; span_ready=1 after reset deasserts. Reset during WALK drops the in-flight span with no further pixels.
- Latency: span accepted at edge N produces first pix_valid=1 in cycle N+1.
- Throughput: 1 pixel/cycle under pix_ready=1. A span of length L occupies L cycles. Back-to-back spans run gap-free.
- pix_* registered outputs. span_ready is combinational from state, pix_last and pix_ready. There is no combinational path from span_* to pix_*.

## Configuration
- SPAN_WALKER_CLIP_EN defined: on accept, if y>=V_ACTIVE or lo>=H_ACTIVE, the span is accepted and discarded, and the block stays IDLE with no pixels. Otherwise hi is clamped to H_ACTIVE-1. pix_last marks the clamped end.
- Undefined: no clipping. H_ACTIVE and V_ACTIVE are unused. All coordinates up to 2^COORD_W-1 are emitted.

## Structure
- Shared package gpu_pkg: COORD_W, COLOR_W, H_ACTIVE, V_ACTIVE defaults; coord_t, color_t typedefs; span FSM state enum.
- One sub-module: span_minmax (combinational endpoint ordering, plus clamp/discard decision under SPAN_WALKER_CLIP_EN). The FSM, counter and outputs live in span_walker.

## Test plan
- Reset mid-span (y=5, x 10..20, after 3 pixels) -> pix_valid=0, busy=0, outputs 0 immediately; next span y=6, x 1..1 emits a single pixel (1,6) with pix_last=1.
- Span y=7, x_start=3, x_end=6, colour 0xA5, pix_ready=1 -> pixels x=3,4,5,6 on consecutive cycles, y=7, colour 0xA5, pix_last only on x=6; first pixel one cycle after accept.
- Reversed span x_start=9, x_end=4 -> pixels 4..9 ascending, 6 beats.
- Two spans back-to-back (y=1, x 0..1; y=2, x 5..5) with span_valid held -> 3 consecutive pixel cycles, no bubble; second accept coincides with the last-pixel handshake.
- Backpressure: pix_ready toggling 1,0,0,1,... on span x 0..3 -> pix_x/pix_y/pix_color/pix_last stable while stalled; exactly 4 handshakes; span_ready=0 until the final one.
- With SPAN_WALKER_CLIP_EN: span y=10, x 630..700 -> pixels 630..639, pix_last at 639. Span y=480, x 0..5 -> accepted, no pixels. Span y=3, x 1023..1023 without the macro -> one pixel, x=1023, no wrap.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared raster-pipeline types: coordinate/colour widths, visible area
// defaults and the span walker state encoding.
package gpu_pkg;

  localparam int COORD_W  = 10;
  localparam int COLOR_W  = 8;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COLOR_W-1:0] color_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WALK = 1'b1
  } span_state_t;

endpackage

// File: rtl/span_minmax.sv
// Endpoint ordering for a span; with SPAN_WALKER_CLIP_EN also clamps the
// right end to the visible area and flags off-screen spans for discard.
module span_minmax #(
  parameter int COORD_W  = gpu_pkg::COORD_W,
  parameter int H_ACTIVE = gpu_pkg::H_ACTIVE,
  parameter int V_ACTIVE = gpu_pkg::V_ACTIVE
) (
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] x_start,
  input  logic [COORD_W-1:0] x_end,
  output logic [COORD_W-1:0] lo,
  output logic [COORD_W-1:0] hi,
  output logic               discard
);

  logic               swap;
  logic [COORD_W-1:0] hi_raw;

  assign swap   = x_end < x_start;
  assign lo     = swap ? x_end : x_start;
  assign hi_raw = swap ? x_start : x_end;

`ifdef SPAN_WALKER_CLIP_EN
  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_ACTIVE - 1);

  assign discard = (y >= COORD_W'(V_ACTIVE)) ||
                   (lo >= COORD_W'(H_ACTIVE));
  assign hi      = (hi_raw > H_LAST) ? H_LAST : hi_raw;
`else
  logic unused_y;

  assign unused_y = ^y;
  assign discard  = 1'b0;
  assign hi       = hi_raw;
`endif

endmodule

// File: rtl/span_walker.sv
// Span to pixel-stream serialiser with valid/ready on both sides.
// Optional clipping to the visible area: define SPAN_WALKER_CLIP_EN.
module span_walker #(
  parameter int COORD_W  = gpu_pkg::COORD_W,
  parameter int COLOR_W  = gpu_pkg::COLOR_W,
  parameter int H_ACTIVE = gpu_pkg::H_ACTIVE,
  parameter int V_ACTIVE = gpu_pkg::V_ACTIVE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               span_valid,
  output logic               span_ready,
  input  logic [COORD_W-1:0] span_y,
  input  logic [COORD_W-1:0] span_x_start,
  input  logic [COORD_W-1:0] span_x_end,
  input  logic [COLOR_W-1:0] span_color,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [COLOR_W-1:0] pix_color,
  output logic               pix_last,
  output logic               busy
);

  import gpu_pkg::*;

  span_state_t        state;
  logic [COORD_W-1:0] hi_q;
  logic [COORD_W-1:0] lo;
  logic [COORD_W-1:0] hi;
  logic               discard;
  logic               accept;
  logic               load;

  span_minmax #(
    .COORD_W  (COORD_W),
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_minmax (
    .y       (span_y),
    .x_start (span_x_start),
    .x_end   (span_x_end),
    .lo      (lo),
    .hi      (hi),
    .discard (discard)
  );

  // A new span can slot in on the same edge the last pixel leaves.
  assign span_ready = (state == S_IDLE) ||
                      ((state == S_WALK) && pix_last && pix_ready);
  assign accept     = span_valid && span_ready;
  assign load       = accept && !discard;
  assign pix_valid  = (state == S_WALK);
  assign busy       = (state == S_WALK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      hi_q      <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_color <= '0;
      pix_last  <= 1'b0;
    end else if (load) begin
      state     <= S_WALK;
      hi_q      <= hi;
      pix_x     <= lo;
      pix_y     <= span_y;
      pix_color <= span_color;
      pix_last  <= (lo == hi);
    end else if ((state == S_WALK) && pix_ready) begin
      if (pix_last) begin
        state    <= S_IDLE;
        pix_last <= 1'b0;
      end else begin
        // cur < hi here, so the increment can never wrap
        pix_x    <= pix_x + COORD_W'(1);
        pix_last <= ((pix_x + COORD_W'(1)) == hi_q);
      end
    end
  end

endmodule

// File: tb/tb_span_walker.sv
// Scoreboard bench for span_walker: spans expand into an expected pixel
// queue; a monitor compares every offered pixel and handshake.
module tb_span_walker;

  localparam int CW = 10;
  localparam int KW = 8;
  localparam int HA = 640;
  localparam int VA = 480;

  typedef struct {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [KW-1:0] c;
    logic          last;
  } pix_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          span_valid = 1'b0;
  logic          span_ready;
  logic [CW-1:0] span_y = '0;
  logic [CW-1:0] span_x_start = '0;
  logic [CW-1:0] span_x_end = '0;
  logic [KW-1:0] span_color = '0;
  logic          pix_valid;
  logic          pix_ready = 1'b1;
  logic [CW-1:0] pix_x;
  logic [CW-1:0] pix_y;
  logic [KW-1:0] pix_color;
  logic          pix_last;
  logic          busy;

  int   checks = 0;
  int   failures = 0;
  int   pops = 0;
  int   rmode = 0;
  int   pat_i = 0;
  pix_t q[$];

  span_walker dut (
    .clk          (clk),
    .rst          (rst),
    .span_valid   (span_valid),
    .span_ready   (span_ready),
    .span_y       (span_y),
    .span_x_start (span_x_start),
    .span_x_end   (span_x_end),
    .span_color   (span_color),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_color    (pix_color),
    .pix_last     (pix_last),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: a span is the inclusive run of x from min to max endpoint.
  function automatic void expand(input logic [CW-1:0] y,
                                 input logic [CW-1:0] xs,
                                 input logic [CW-1:0] xe,
                                 input logic [KW-1:0] c);
    int lo;
    int hi;
    pix_t p;
    lo = (int'(xs) < int'(xe)) ? int'(xs) : int'(xe);
    hi = (int'(xs) < int'(xe)) ? int'(xe) : int'(xs);
`ifdef SPAN_WALKER_CLIP_EN
    if (int'(y) >= VA || lo >= HA) return;
    if (hi > HA - 1) hi = HA - 1;
`endif
    for (int x = lo; x <= hi; x++) begin
      p.x    = CW'(x);
      p.y    = y;
      p.c    = c;
      p.last = (x == hi);
      q.push_back(p);
    end
  endfunction

  always @(negedge clk) begin
    case (rmode)
      0: pix_ready = 1'b1;
      1: pix_ready = 1'($urandom_range(0, 1));
      default: begin
        pix_ready = ((pat_i % 4) == 0) || ((pat_i % 4) == 3);
        pat_i++;
      end
    endcase
  end

  // Monitor: runs after all inputs for the coming edge are settled.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      logic eb;
      logic er;
      eb = (q.size() > 0);
      er = !eb || (q[0].last && pix_ready);
      chk("busy", 32'(busy), 32'(eb));
      chk("pix_valid", 32'(pix_valid), 32'(eb));
      chk("span_ready", 32'(span_ready), 32'(er));
      if (eb && pix_valid) begin
        chk("pix_x", 32'(pix_x), 32'(q[0].x));
        chk("pix_y", 32'(pix_y), 32'(q[0].y));
        chk("pix_color", 32'(pix_color), 32'(q[0].c));
        chk("pix_last", 32'(pix_last), 32'(q[0].last));
        if (pix_ready) begin
          void'(q.pop_front());
          pops++;
        end
      end
    end
  end

  task automatic send(input logic [CW-1:0] y, input logic [CW-1:0] xs,
                      input logic [CW-1:0] xe, input logic [KW-1:0] c);
    int  n;
    bit  acc;
    n   = 0;
    acc = 0;
    @(negedge clk);
    span_valid   = 1'b1;
    span_y       = y;
    span_x_start = xs;
    span_x_end   = xe;
    span_color   = c;
    while (!acc) begin
      #1;
      acc = span_ready;
      @(posedge clk);
      if (acc) begin
        expand(y, xs, xe, c);
      end else begin
        n++;
        if (n > 3000) begin
          chk("accept_timeout", 32'(n), 32'(0));
          break;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    span_valid   = 1'b0;
    span_y       = CW'($urandom);
    span_x_start = CW'($urandom);
    span_x_end   = CW'($urandom);
    span_color   = KW'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(q.size()), 32'(0));
    @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_valid"}, 32'(pix_valid), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_last"}, 32'(pix_last), 32'(0));
    chk({tag, "_x"}, 32'(pix_x), 32'(0));
    chk({tag, "_y"}, 32'(pix_y), 32'(0));
    chk({tag, "_color"}, 32'(pix_color), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int n;
    int xs;
    int xe;
    #1;
    reset_checks("rst0");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(span_ready), 32'(1));

    // Reset in the middle of a span drops it.
    rmode = 0;
    send(5, 10, 20, 8'h33);
    idle();
    n = 0;
    while (pops < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    reset_checks("rst_mid");
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst2", 32'(span_ready), 32'(1));
    send(6, 1, 1, 8'h11);
    idle();
    drain();

    send(7, 3, 6, 8'hA5);
    idle();
    drain();
    send(8, 9, 4, 8'h5A);
    idle();
    drain();

    // Back-to-back with valid held: the monitor's span_ready/pix_valid
    // checks fail on any bubble.
    send(1, 0, 1, 8'h01);
    send(2, 5, 5, 8'h02);
    idle();
    drain();

    rmode = 2;
    pat_i = 0;
    send(4, 0, 3, 8'hC3);
    idle();
    drain();
    rmode = 0;

`ifdef SPAN_WALKER_CLIP_EN
    send(10, 630, 700, 8'h77);
    idle();
    drain();
    send(480, 0, 5, 8'h66);
    idle();
    drain();
`else
    send(3, 1023, 1023, 8'h99);
    idle();
    drain();
    send(9, 1023, 1015, 8'h98);
    idle();
    drain();
`endif

    rmode = 1;
    for (int i = 0; i < 150; i++) begin
      xs = (i % 10 == 0) ? 1023 - $urandom_range(0, 3)
                         : $urandom_range(0, 1023);
      xe = xs + $urandom_range(0, 24) - 12;
      if (xe < 0) xe = 0;
      if (xe > 1023) xe = 1023;
      if (i % 3 == 0) xe = xs;
      send(CW'($urandom_range(0, 511)), CW'(xs), CW'(xe), KW'($urandom));
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
